// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset PC and fetch-state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection from decoder controls: jr > jump > branch > sequential.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] pc_plus4,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic [WORD_WIDTH-1:0] rs_data,
    input  logic                  pc_src,
    input  logic                  jump,
    input  logic                  jr,
    output logic [WORD_WIDTH-1:0] next_pc,
    output logic                  misaligned
);

    logic [WORD_WIDTH-1:0] br_off;

    assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (pc_src) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    // Only a register-sourced target can be misaligned in practice.
    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and holds inst for execute.
//   state | meaning
//   IDLE  | one dead cycle after reset, then request
//   REQ   | imem_req high at pc, waiting for ack (timeout -> HALT)
//   EXEC  | inst valid downstream; leave on !stall with next pc
//   HALT  | fetch error latched, only reset exits
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = fetch_unit_pkg::RESET_PC,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH     = 5
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        pc_src,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           inst_q, inst_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [31:0]           next_pc;
    logic                  misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4   (pc_plus4),
        .inst       (inst_q),
        .rs_data    (rs_data),
        .pc_src     (pc_src),
        .jump       (jump),
        .jr         (jr),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == ST_EXEC);
    assign pc         = pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequencing, control flow, stall, slow memory, timeout, misalignment.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        pc_src;
    logic        jump;
    logic        jr;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16),
        .CNT_WIDTH     (5)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .pc_src     (pc_src),
        .jump       (jump),
        .jr         (jr),
        .rs_data    (rs_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack_word(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic exec_go(input logic b, input logic j, input logic r, input logic [31:0] rs);
        pc_src  = b;
        jump    = j;
        jr      = r;
        rs_data = rs;
        step();
        pc_src  = 1'b0;
        jump    = 1'b0;
        jr      = 1'b0;
        rs_data = 32'h0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        imem_ack = 0; imem_rdata = 0; stall = 0;
        pc_src = 0; jump = 0; jr = 0; rs_data = 0;
        nrst = 0;
        @(negedge clk);
        step();

        chk_val("rst_pc",        pc,         32'h0);
        chk_val("rst_inst",      inst,       32'h0);
        chk_val("rst_valid",     inst_valid, 32'h0);
        chk_val("rst_req",       imem_req,   32'h0);
        chk_val("rst_err",       fetch_err,  32'h0);
        chk_val("rst_pc_plus4",  pc_plus4,   32'h4);

        nrst = 1'b1;
        chk_val("idle_req", imem_req, 32'h0);
        step();
        chk_val("first_req",  imem_req,  32'h1);
        chk_val("first_addr", imem_addr, 32'h0);
        ack_word(32'h2008_0005);
        chk_val("first_inst",  inst,       32'h2008_0005);
        chk_val("first_valid", inst_valid, 32'h1);
        chk_val("exec_req",    imem_req,   32'h0);
        exec_go(0, 0, 0, 32'h0);
        chk_val("seq_pc",   pc,        32'h4);
        chk_val("seq_addr", imem_addr, 32'h4);
        chk_val("seq_req",  imem_req,  32'h1);

        for (int k = 0; k < 3; k++) begin
            ack_word(32'h0);
            exec_go(0, 0, 0, 32'h0);
        end
        chk_val("pc_at_10", pc, 32'h10);

        ack_word(32'h1000_FFFE);
        exec_go(1, 0, 0, 32'h0);
        chk_val("beq_back_addr", imem_addr, 32'h0C);

        ack_word(32'h0800_0010);
        exec_go(0, 1, 0, 32'h0);
        chk_val("jump_addr", imem_addr, 32'h40);

        ack_word(32'h0800_0010);
        exec_go(0, 1, 1, 32'h100);
        chk_val("jr_over_jump", imem_addr, 32'h100);

        ack_word(32'h2009_0007);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_val("stall_inst",  inst,       32'h2009_0007);
            chk_val("stall_pc",    pc,         32'h100);
            chk_val("stall_valid", inst_valid, 32'h1);
            chk_val("stall_req",   imem_req,   32'h0);
            step();
        end
        stall = 1'b0;
        step();
        chk_val("unstall_req",  imem_req,  32'h1);
        chk_val("unstall_addr", imem_addr, 32'h104);

        for (int k = 0; k < 6; k++) begin
            chk_val("slow_req_hi", imem_req, 32'h1);
            step();
        end
        chk_val("slow_req_7th", imem_req, 32'h1);
        ack_word(32'h200A_0003);
        chk_val("slow_inst",  inst,       32'h200A_0003);
        chk_val("slow_valid", inst_valid, 32'h1);
        chk_val("slow_err",   fetch_err,  32'h0);
        exec_go(0, 0, 0, 32'h0);
        chk_val("to_addr", imem_addr, 32'h108);

        req_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (!imem_req) break;
            req_cycles++;
            step();
        end
        chk_val("to_req_cycles", req_cycles, 32'd16);
        chk_val("to_err",        fetch_err,  32'h1);
        chk_val("to_req_low",    imem_req,   32'h0);
        chk_val("to_valid_low",  inst_valid, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        chk_val("halt_inst_held", inst,      32'h200A_0003);
        chk_val("halt_req",       imem_req,  32'h0);
        chk_val("halt_err",       fetch_err, 32'h1);
        chk_val("halt_pc",        pc,        32'h108);
        nrst = 1'b0;
        #1;
        chk_val("rst_clears_err", fetch_err, 32'h0);
        chk_val("rst_clears_pc",  pc,        32'h0);
        @(negedge clk);
        nrst = 1'b1;

        step();
        ack_word(32'h03E0_0008);
        exec_go(0, 0, 1, 32'h0000_0102);
        chk_val("mis_err",   fetch_err,  32'h1);
        chk_val("mis_pc",    pc,         32'h0);
        chk_val("mis_req",   imem_req,   32'h0);
        chk_val("mis_valid", inst_valid, 32'h0);
        step();
        chk_val("mis_halt_req", imem_req, 32'h0);

        do_reset();
        step();
        ack_word(32'h0);
        exec_go(0, 0, 0, 32'h0);
        chk_val("mid_req_before", imem_req, 32'h1);
        chk_val("mid_pc_before",  pc,       32'h4);
        #2;
        nrst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        #1;
        chk_val("async_req_low", imem_req, 32'h0);
        chk_val("async_pc",      pc,       32'h0);
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk_val("late_ack_inst", inst,     32'h0);
        chk_val("late_ack_req",  imem_req, 32'h1);
        imem_ack = 1'b0; imem_rdata = 32'h0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction decoder/controller. It owns the PC and drives a request/acknowledge instruction-memory port. It holds the fetched word stable on `inst` for the decoder and the datapath while the instruction executes. It consumes the decoder's `pc_src`/`jump`/`jr` outputs to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum number of REQ cycles without `imem_ack` before a fetch error is raised.
- CNT_WIDTH, 5, width of the timeout counter; must hold FETCH_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ack  in  1  memory has returned data on `imem_rdata` this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  registered instruction word, to the decoder and datapath.
- inst_valid  out  1  `inst` is executing this cycle (EXEC state).
- stall  in  1  downstream busy (e.g. data memory); holds EXEC.
- pc_src  in  1  branch taken, from the decoder.
- jump  in  1  j/jal, from the decoder.
- jr  in  1  jr, from the decoder.
- rs_data  in  32  register-file rs read value, used as the jr target.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, the jal link value.
- fetch_err  out  1  sticky error flag.

Behaviour:
- **Reset (async, nrst=0):**
  - pc=RESET_PC, inst=32'h0 (nop), inst_valid=0, imem_req=0, fetch_err=0.
  - Counter=0, state=IDLE.
  - Reset mid-fetch abandons the request immediately; a late `imem_ack` is ignored.
- **States:** IDLE, REQ, EXEC, HALT.
- **IDLE:** goes to REQ on the next cycle unconditionally. The first request is asserted in the 2nd cycle after reset release.
- **REQ:**
  - imem_req=1, imem_addr=pc.
  - On `imem_ack` (allowed in the first REQ cycle): inst<=imem_rdata, counter<=0, go to EXEC.
  - Otherwise the counter increments. When the counter reaches FETCH_TIMEOUT-1 without an ack: fetch_err<=1, go to HALT.
- **EXEC:**
  - inst_valid=1, imem_req=0.
  - If stall=1: hold everything (pc, inst, state).
  - If stall=0: pc<=next_pc, go to REQ.
  - Best-case throughput is 2 cycles per instruction.
- **next_pc priority:** jr > jump > pc_src > sequential.
  - jr: rs_data.
  - jump: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - pc_src: pc_plus4 + ({{14{inst[15]}}, inst[15:0], 2'b00}). Mod-2^32 wrap is legal.
  - Sequential: pc_plus4. 32'hFFFF_FFFC+4 wraps to 0.
- **Misaligned target:** if the selected next_pc[1:0]≠0 when leaving EXEC, fetch_err<=1, pc is unchanged, go to HALT.
- **HALT:** imem_req=0, inst_valid=0, inst is held. Only reset exits HALT.
- **Decoder inputs:** pc_src/jump/jr/rs_data are sampled only in EXEC with stall=0 and are ignored elsewhere.
- **Combinational output:** pc_plus4 = pc+4 at all times.

Decomposition:
- Shared defines: WORD_WIDTH, RESET_PC, and the fetch state encoding (IDLE=2'd0, REQ=2'd1, EXEC=2'd2, HALT=2'd3).
- One combinational sub-module, `next_pc_sel`: inputs pc_plus4, inst, rs_data, pc_src, jump, jr; outputs next_pc and misaligned.

Test Plan:
- **Reset/first fetch:** release nrst; memory acks in the first REQ cycle with 32'h2008_0005 → imem_req rises in the 2nd cycle after release with imem_addr=0; inst=32'h2008_0005 and inst_valid=1 one cycle later; pc=4 in the following cycle.
- **Branch/jump:**
  - pc=32'h10, inst=beq with imm=16'hFFFE, pc_src=1 → next imem_addr=32'h0C.
  - jump with inst[25:0]=26'h10 → next imem_addr=32'h40.
  - jr and jump both high with rs_data=32'h100 → next imem_addr=32'h100.
- **Stall:** hold stall=1 for 3 EXEC cycles → inst, pc and inst_valid remain stable and imem_req=0. Deassert stall → REQ with addr=pc+4.
- **Slow memory:** ack after 7 REQ cycles → imem_req stays high for 7 cycles, then inst is captured with no error.
- **Timeout:** no ack → fetch_err=1 after FETCH_TIMEOUT(16) REQ cycles; imem_req=0 thereafter. Raising imem_ack afterwards has no effect; reset clears fetch_err.
- **Misaligned jr:** rs_data=32'h0000_0102 → fetch_err=1, pc unchanged, state HALT. Async reset asserted mid-REQ → imem_req=0 and pc=RESET_PC immediately, before the next clock edge.
